// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: sequential restoring divider, one quotient bit per clock.
// It shares the Run/switch-load handshake of the add/shift multiplier: a Run
// rising edge samples A and B, the unit iterates, then results are shown
// while Run is held.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's complement operands,
// adds a sign-fix state, truncates toward zero).
// Quotient, Remainder and DivZero come straight from registers and keep
// their values in IDLE until the next start.

module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_nextState;
    logic             r_runPrev;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    // The restored partial remainder is always below the divisor, so it
    // fits in WIDTH bits; the WIDTH+1-bit value only exists transiently
    // as the shifted remainder and the trial difference.
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divZero;
    logic             w_start;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_lastIter;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             r_aNeg;
    logic             r_bNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

    assign w_absA = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign w_absB = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
`endif

    assign w_start    = Run && !r_runPrev;
    assign w_shifted  = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_m};
    assign w_lastIter = (r_count == CW'(WIDTH));

    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign DivZero   = r_divZero;
    assign Done      = (r_state == S_DONE);
`ifdef SEQ_DIVIDER_SIGNED_EN
    assign Busy      = (r_state == S_DIV) || (r_state == S_FIX);
`else
    assign Busy      = (r_state == S_DIV);
`endif

    // State register; reset drops any division in progress back to IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: start only on a Run rising edge, leave DONE when Run drops.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nextState = S_DIV;
                end
            end
            S_DIV: begin
                if (w_lastIter) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    w_nextState = S_FIX;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            S_FIX: begin
                w_nextState = S_DONE;
            end
`endif
            S_DONE: begin
                if (!Run) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on start, one restoring step per DIV cycle,
    // and publish the result registers once the last step has settled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_runPrev   <= 1'b0;
            r_q         <= '0;
            r_m         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divZero   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_aNeg      <= 1'b0;
            r_bNeg      <= 1'b0;
`endif
        end else begin
            r_runPrev <= Run;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_q    <= w_absA;
                        r_m    <= w_absB;
                        r_aNeg <= A[WIDTH-1];
                        r_bNeg <= B[WIDTH-1];
`else
                        r_q    <= A;
                        r_m    <= B;
`endif
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_divZero <= (B == '0);
                    end
                end
                S_DIV: begin
                    if (w_lastIter) begin
`ifndef SEQ_DIVIDER_SIGNED_EN
                        r_quotient  <= r_q;
                        r_remainder <= r_rem;
`endif
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shifted[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                        r_count <= r_count + CW'(1);
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                // Sign fix: on divide-by-zero the quotient stays all ones, and
                // negating |A| for a negative A hands back the raw A.
                S_FIX: begin
                    if ((r_aNeg ^ r_bNeg) && !r_divZero) begin
                        r_quotient <= ~r_q + WIDTH'(1);
                    end else begin
                        r_quotient <= r_q;
                    end
                    if (r_aNeg) begin
                        r_remainder <= ~r_rem + WIDTH'(1);
                    end else begin
                        r_remainder <= r_rem;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// tb_seq_divider_8bit: table-driven checks of the unsigned divider plus
// hand-written handshake, ignored-input and mid-division reset sequences.

module tb_seq_divider_8bit;

    logic       Clk;
    logic       Reset_n;
    logic       Run;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[10];

    seq_divider_8bit #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Run       (Run),
        .A         (A),
        .B         (B),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    // 10 ns clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something wedges the stimulus
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a division with a Run rising edge and wait (bounded) for Done;
    // lat is the number of clock edges after the start edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge Clk);
        A   = a;
        B   = b;
        Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("busy_after_start", Busy, 1);
        checkOutput("done_after_start", Done, 0);
        lat = 0;
        while (lat < 20 && !Done) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
    endtask

    // Drop Run and let the unit return to IDLE
    task automatic releaseRun();
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'd200, 8'd7,   8'h1C, 8'h04, 1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'hFF, 8'h00, 1'b0};
        vecs[2] = '{8'd3,   8'd10,  8'h00, 8'h03, 1'b0};
        vecs[3] = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1};
        vecs[5] = '{8'd100, 8'd10,  8'h0A, 8'h00, 1'b0};
        vecs[6] = '{8'd255, 8'd255, 8'h01, 8'h00, 1'b0};
        vecs[7] = '{8'd254, 8'd16,  8'h0F, 8'h0E, 1'b0};
        vecs[8] = '{8'd128, 8'd3,   8'h2A, 8'h02, 1'b0};
        vecs[9] = '{8'd1,   8'd255, 8'h00, 8'h01, 1'b0};

        Reset_n = 1'b0;
        Run     = 1'b0;
        A       = 8'h00;
        B       = 8'h00;

        #12;
        checkOutput("reset_quotient",  Quotient,  0);
        checkOutput("reset_remainder", Remainder, 0);
        checkOutput("reset_busy",      Busy,      0);
        checkOutput("reset_done",      Done,      0);
        checkOutput("reset_divzero",   DivZero,   0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            checkOutput("latency",   lat,       9);
            checkOutput("quotient",  Quotient,  vecs[i].q);
            checkOutput("remainder", Remainder, vecs[i].r);
            checkOutput("divzero",   DivZero,   vecs[i].dz);
            checkOutput("busy_done", Busy,      0);
            releaseRun();
            checkOutput("idle_done",      Done,      0);
            checkOutput("idle_quotient",  Quotient,  vecs[i].q);
            checkOutput("idle_remainder", Remainder, vecs[i].r);
            checkOutput("idle_divzero",   DivZero,   vecs[i].dz);
        end

        $display("[TB] handshake: Run held high after Done");
        applyStimulus(8'd17, 8'd5, lat);
        checkOutput("hs_latency",   lat,       9);
        checkOutput("hs_quotient",  Quotient,  8'h03);
        checkOutput("hs_remainder", Remainder, 8'h02);
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            checkOutput("hs_hold_done", Done, 1);
            checkOutput("hs_hold_busy", Busy, 0);
        end
        releaseRun();
        checkOutput("hs_idle_done", Done, 0);
        checkOutput("hs_idle_busy", Busy, 0);
        repeat (3) @(negedge Clk);
        checkOutput("hs_held_quotient",  Quotient,  8'h03);
        checkOutput("hs_held_remainder", Remainder, 8'h02);
        checkOutput("hs_held_busy",      Busy,      0);

        $display("[TB] restart with operand and Run changes during DIV");
        @(negedge Clk);
        A   = 8'd100;
        B   = 8'd9;
        Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("rs_busy", Busy, 1);
        A   = 8'd1;
        B   = 8'd1;
        Run = 1'b0;
        @(posedge Clk);
        lat = 1;
        @(negedge Clk);
        Run = 1'b1;
        while (lat < 20 && !Done) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        checkOutput("rs_latency",   lat,       9);
        checkOutput("rs_quotient",  Quotient,  8'h0B);
        checkOutput("rs_remainder", Remainder, 8'h01);
        releaseRun();

        $display("[TB] asynchronous reset mid-division");
        @(negedge Clk);
        A   = 8'd200;
        B   = 8'd7;
        Run = 1'b1;
        @(posedge Clk);
        repeat (4) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("rst_busy",      Busy,      0);
        checkOutput("rst_done",      Done,      0);
        checkOutput("rst_quotient",  Quotient,  0);
        checkOutput("rst_remainder", Remainder, 0);
        checkOutput("rst_divzero",   DivZero,   0);
        Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("rst_idle_busy", Busy, 0);
        checkOutput("rst_idle_done", Done, 0);
        applyStimulus(8'd200, 8'd7, lat);
        checkOutput("rst_rerun_latency",   lat,       9);
        checkOutput("rst_rerun_quotient",  Quotient,  8'h1C);
        checkOutput("rst_rerun_remainder", Remainder, 8'h04);
        checkOutput("rst_rerun_divzero",   DivZero,   0);
        releaseRun();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider_8bit.md
Name: seq_divider_8bit

Overview:
- Sequential restoring divider; the inverse companion of the add/shift multiplier datapath.
- Each cycle it uses a WIDTH+1-bit subtract to produce one quotient bit.
- Sits beside the multiplier in the lab top level and shares the same Run/switch-load user interface.
- Results drive the hex displays.

Parameters:
WIDTH, 8, operand/result width; the partial remainder is WIDTH+1 bits.

Ports:
Clk  input  1  system clock, rising-edge.
Reset_n  input  1  asynchronous, active-low reset.
Run  input  1  start request, level; must be low then high to start a new division.
A  input  WIDTH  dividend, sampled at start.
B  input  WIDTH  divisor, sampled at start.
Quotient  output  WIDTH  quotient result.
Remainder  output  WIDTH  remainder result.
Busy  output  1  high while iterating.
Done  output  1  high while results are valid and Run is still held.
DivZero  output  1  set when the sampled B was zero.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset_n low, at any time including mid-division, forces:
  - state IDLE;
  - Quotient, Remainder, count and M register to 0;
  - Busy, Done, DivZero to 0.
- State IDLE:
  - Entry condition for a new start: Run=1 at a rising edge AND Run was 0 at the previous edge.
  - On that edge, load: Q register <- A; M <- B; R (WIDTH+1 bits) <- 0; count <- 0; DivZero <- (B==0). Go to DIV.
- State DIV (Busy=1), one iteration per edge:
  - {R,Q} is shifted left 1, with the MSB of Q entering the LSB of R.
  - trial = R_shifted - {1'b0,M}, computed at WIDTH+1 bits.
  - If trial[WIDTH]==0: R <- trial, Q[0] <- 1. Otherwise R is kept as shifted and Q[0] <- 0.
  - count increments each iteration. After the edge that performs iteration WIDTH, go to DONE.
- State DONE (Done=1):
  - Quotient = Q, Remainder = R[WIDTH-1:0].
  - Stay in DONE while Run=1. Go to IDLE on the first edge with Run=0.
- Latency: Done rises WIDTH+1 edges after the start edge, i.e. 9 for WIDTH=8.
- Quotient, Remainder and DivZero hold their values in IDLE until the next start.
- Run held high continuously after DONE never restarts the unit.
- Run changes in DIV are ignored. A, B changes after the start edge are ignored.
- Divide by zero:
  - The iteration runs normally, giving Quotient = all ones and Remainder = A.
  - DivZero=1. Latency is unchanged.
- Quotient and Remainder are stable outputs directly from registers. No combinational path from A/B.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined, operands are two's complement:
  - At start, M and Q load |B| and |A|. The signs of A and B are latched.
  - A FIX state is inserted between DIV and DONE. In it, Quotient is negated if sign(A)!=sign(B), and Remainder is negated if A<0.
  - Division truncates toward zero. Latency becomes WIDTH+2.
  - -128/-1 wraps to Quotient 0x80, Remainder 0x00.
  - If DivZero, FIX skips correction: outputs are all ones and raw A.
- When undefined: unsigned only, no FIX state, latency WIDTH+1.

Test Plan:
- Unsigned basic: A=200, B=7, Run pulsed -> after 9 edges Done=1, Quotient=0x1C, Remainder=0x04, DivZero=0.
- Boundaries: 255/1 -> Q=0xFF, R=0x00. 3/10 -> Q=0x00, R=0x03. 0/5 -> Q=0x00, R=0x00.
- Divide by zero: A=5, B=0 -> after 9 edges DivZero=1, Q=0xFF, R=0x05.
- Handshake: hold Run high for 30 cycles after Done -> exactly one division, Done stays 1. Then Run low -> IDLE, Done=0, results held. Then Run high -> new division starts.
- Reset mid-op: start 200/7, assert Reset_n low asynchronously between edges 4 and 5 -> immediately Busy=0, Done=0, Q=R=0, state IDLE. After release, the next Run edge starts cleanly.
- With SEQ_DIVIDER_SIGNED_EN: A=0x9C (-100), B=0x07 -> after 10 edges Q=0xF2 (-14), R=0xFE (-2). Also 0x80 / 0xFF -> Q=0x80, R=0x00.
